alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer for the shared 32-bit combinational ALU. Accepts operation requests from two requesters (port 0: integer execute path, port 1: address/PC-update path). Grants them round-robin and drives the ALU from latched operands. Owns the integer condition-code register (icc = N,Z,C,V), which supplies carry-in and is updated only by cc-modifying opcodes.

## Interface
- No parameters; widths fixed (32-bit data, 6-bit opcode).
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req0, req1  in  1  request, level; held until matching done
- op0, op1  in  6  ALU opcode (ALU encoding)
- a0, b0, a1, b1  in  32  operands
- gnt0, gnt1  out  1  one-cycle pulse: operands of that port captured
- done0, done1  out  1  one-cycle pulse: y/nzcv valid for that port
- y  out  32  registered result of last completed operation
- nzcv  out  4  icc register {N,Z,C,V}
- icc_ld  in  1  load icc from icc_in (wrpsr path)
- icc_in  in  4  value loaded into icc
- alu_op  out  6  to ALU op
- alu_a, alu_b  out  32  to ALU A, B
- alu_ci  out  1  to ALU Ci = icc C
- alu_y  in  32  from ALU Y
- alu_n, alu_z, alu_c, alu_v  in  1  from ALU flags

## Operation
- FSM states: IDLE, EXEC, DONE. Reset → IDLE.
- IDLE: samples req0/req1.
  - Neither request: stay in IDLE.
  - One request: latch that port's op/a/b and the port id, assert its gnt next cycle, go to EXEC.
  - Both requests: grant the port not served last (last-served pointer `lsp`). After reset lsp = 1, so port 0 wins first.
- EXEC: alu_op/alu_a/alu_b driven from the latched registers; alu_ci = icc C.
  - At end of EXEC: y ← alu_y.
  - If latched op[5:4] == 2'b01 (cc opcodes 010000–011111), icc ← {alu_n, alu_z, alu_c, alu_v}.
  - lsp ← served port; go to DONE.
- DONE: done of served port high, other done low; go to IDLE.
- Requester protocol: drop req in the done cycle. A req still high in IDLE starts a new transaction.
- Outside EXEC, alu_op/alu_a/alu_b hold the last latched values. No glitching to zero.
- Non-cc opcodes never change icc. y is kept until the next completed operation.
- icc_ld and a cc-update at the same edge: icc_ld wins, icc ← icc_in. icc_ld in any state loads at that edge.
- Opcodes are not checked. Undefined opcodes pass through; y takes whatever the ALU produces.

## Timing
- Reset values: gnt0 = gnt1 = done0 = done1 = 0; y = 0; nzcv = 0000; alu_op = 0; alu_a = alu_b = 0; alu_ci = 0; lsp = 1; state IDLE.
- Reset mid-transaction aborts it: no done is issued, icc is not updated.
- Single request:
  - req seen high at edge E0 → gnt high in cycle E0–E1 (state EXEC).
  - y/icc written at E1 → done high in cycle E1–E2 (state DONE).
  - IDLE again after E2.
- Latency: 2 cycles from sampling edge to done. Throughput: one operation per 3 cycles.
- gnt and done are registered outputs, never high together for the same port. Exactly one gnt and one done per transaction.
- Back-to-back alternating requests are served 0,1,0,1… with no idle cycle beyond the IDLE state.
- alu_ci reflects icc at EXEC, including an icc_ld that landed in the preceding edge.

## Test plan
- Reset, then req0 with op=010000 (addcc), a0=8, b0=7 → gnt0 cycle 1, done0 cycle 2, y=15, nzcv=0000, gnt1/done1 never high.
- req1 with op=010100 (subcc), a1=7, b1=8 → y=32'hFFFFFFFF, nzcv=1010. A following req0 op=000000 (add) 8+7 gives y=15 and leaves nzcv=1010.
- icc_ld=1, icc_in=0010 (C=1), then req0 op=001000 (addx), 8+7 → alu_ci=1, y=16, nzcv=0010. Repeat with op=011000 → y=16, nzcv=0000.
- req0 and req1 both held high across three transactions (port 0 addcc 1+1, port 1 addcc 2+2) → grant order 0,1,0; y=2,4,2; each done on the correct port.
- icc_ld=1 with icc_in=1111 on the same edge that ends EXEC of addcc 8+7 → nzcv=1111, y=15.
- Reset asserted during EXEC of subcc 7−8 → all outputs to reset values immediately, no done, nzcv=0000. After release, req1 alone is served first (lsp=1 means port 0 is preferred only on a tie).

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared 32-bit ALU.
// Latches the granted port's operands, runs one EXEC cycle, and owns the icc register.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [5:0]  op0,
  input  logic [5:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] y,
  output logic [3:0]  nzcv,
  input  logic        icc_ld,
  input  logic [3:0]  icc_in,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_ci,
  input  logic [31:0] alu_y,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        sel_q,   sel_d;
  logic        lsp_q,   lsp_d;
  logic [5:0]  op_q,    op_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [31:0] y_q,     y_d;
  logic [3:0]  icc_q,   icc_d;
  logic [1:0]  gnt_q,   gnt_d;
  logic [1:0]  done_q,  done_d;
  logic        pick;

  // On a tie the port not served last wins; otherwise whichever port is asking.
  assign pick = (req0 && req1) ? ~lsp_q : req1;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    state_d = state_q;
    sel_d   = sel_q;
    lsp_d   = lsp_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    icc_d   = icc_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          sel_d       = pick;
          op_d        = pick ? op1 : op0;
          a_d         = pick ? a1  : a0;
          b_d         = pick ? b1  : b0;
          gnt_d[pick] = 1'b1;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        y_d = alu_y;
        if (op_q[5:4] == 2'b01) begin
          icc_d = {alu_n, alu_z, alu_c, alu_v};
        end
        lsp_d          = sel_q;
        done_d[sel_q]  = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A wrpsr load overrides any flag update landing on the same edge.
    if (icc_ld) begin
      icc_d = icc_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      lsp_q   <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      icc_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lsp_q   <= lsp_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      icc_q   <= icc_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign gnt0   = gnt_q[0];
  assign gnt1   = gnt_q[1];
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign y      = y_q;
  assign nzcv   = icc_q;
  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_ci = icc_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, hand-written corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [5:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] y;
  logic [3:0]  nzcv;
  logic        icc_ld;
  logic [3:0]  icc_in;
  logic [5:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        alu_ci;
  logic [31:0] alu_y;
  logic        alu_n, alu_z, alu_c, alu_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .y(y), .nzcv(nzcv), .icc_ld(icc_ld), .icc_in(icc_in),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v)
  );

  // Combinational ALU: add, sub, addx, subx; anything else produces a ^ b with C=V=0.
  function automatic logic [35:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic ci);
    logic [32:0] s;
    logic        v;
    s = '0;
    v = 1'b0;
    case (op[3:0])
      4'b0000: begin
        s = {1'b0, a} + {1'b0, b};
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b0100: begin
        s = {1'b0, a} - {1'b0, b};
        v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'b1000: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b1100: begin
        s = {1'b0, a} - {1'b0, b} - {32'd0, ci};
        v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      default: s = {1'b0, a ^ b};
    endcase
    return {s[31:0], s[31], (s[31:0] == 32'd0), s[32], v};
  endfunction

  assign {alu_y, alu_n, alu_z, alu_c, alu_v} = alu_fn(alu_op, alu_a, alu_b, alu_ci);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 0; req1 = 0; icc_ld = 0; icc_in = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_icc_ld(input logic [3:0] v);
    icc_ld = 1'b1;
    icc_in = v;
    @(negedge clk);
    icc_ld = 1'b0;
  endtask

  // Starts at a negedge while the DUT is idle, raises the requests, checks grant,
  // latency, done and results, drops requests in the done cycle, ends at a negedge in IDLE.
  task automatic run_txn(input string tag, input logic r0, input logic r1, input logic exp_port,
                         input logic [31:0] exp_y, input logic [3:0] exp_nzcv,
                         input logic exp_ci);
    int n;
    logic [1:0] exp_vec;
    exp_vec = exp_port ? 2'b10 : 2'b01;
    req0 = r0;
    req1 = r1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt0 || gnt1) && n < 6);
    check({tag, " gnt"}, {62'd0, gnt1, gnt0}, {62'd0, exp_vec});
    check({tag, " gnt latency"}, n, 1);
    check({tag, " alu_ci"}, alu_ci, exp_ci);
    @(negedge clk);
    check({tag, " done"}, {60'd0, gnt1, gnt0, done1, done0}, {60'd0, 2'b00, exp_vec});
    check({tag, " y"}, y, exp_y);
    check({tag, " nzcv"}, nzcv, exp_nzcv);
    req0 = 0;
    req1 = 0;
    @(negedge clk);
    check({tag, " quiet after done"}, {gnt1, gnt0, done1, done0}, 4'b0000);
  endtask

  typedef struct {
    logic        port;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ld;
    logic [3:0]  ld_val;
    logic [31:0] exp_y;
    logic [3:0]  exp_nzcv;
    logic        exp_ci;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic        m_lsp;
    logic [3:0]  m_icc;
    logic [35:0] r;
    logic        p;
    logic        rr0, rr1;
    logic [5:0]  rop;

    vecs[0] = '{1'b0, 6'b010000, 32'd8, 32'd7, 1'b0, 4'h0, 32'd15,         4'b0000, 1'b0};
    vecs[1] = '{1'b1, 6'b010100, 32'd7, 32'd8, 1'b0, 4'h0, 32'hFFFFFFFF,   4'b1010, 1'b0};
    vecs[2] = '{1'b0, 6'b000000, 32'd8, 32'd7, 1'b0, 4'h0, 32'd15,         4'b1010, 1'b1};
    vecs[3] = '{1'b0, 6'b001000, 32'd8, 32'd7, 1'b1, 4'b0010, 32'd16,      4'b0010, 1'b1};
    vecs[4] = '{1'b0, 6'b011000, 32'd8, 32'd7, 1'b0, 4'h0, 32'd16,         4'b0000, 1'b1};

    // Reset values
    reset = 1'b1;
    req0 = 0; req1 = 0; icc_ld = 0; icc_in = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    #12;
    check("reset handshakes", {gnt1, gnt0, done1, done0}, 4'b0000);
    check("reset y", y, 32'd0);
    check("reset nzcv", nzcv, 4'd0);
    check("reset alu bus", {alu_op, alu_a, alu_b, alu_ci}, 71'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].ld) pulse_icc_ld(vecs[i].ld_val);
      if (vecs[i].port) begin
        op1 = vecs[i].op; a1 = vecs[i].a; b1 = vecs[i].b;
      end else begin
        op0 = vecs[i].op; a0 = vecs[i].a; b0 = vecs[i].b;
      end
      run_txn($sformatf("vec%0d", i), ~vecs[i].port, vecs[i].port, vecs[i].port,
              vecs[i].exp_y, vecs[i].exp_nzcv, vecs[i].exp_ci);
    end
    check("alu_op held in idle", alu_op, 6'b011000);

    // icc_ld landing on the same edge that ends EXEC of addcc
    op0 = 6'b010000; a0 = 32'd8; b0 = 32'd7;
    req0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt0 && n < 6);
    check("ld-vs-cc gnt0", gnt0, 1'b1);
    icc_ld = 1'b1;
    icc_in = 4'b1111;
    @(negedge clk);
    icc_ld = 1'b0;
    req0 = 1'b0;
    check("ld-vs-cc done0", done0, 1'b1);
    check("ld-vs-cc y", y, 32'd15);
    check("ld-vs-cc nzcv", nzcv, 4'b1111);
    @(negedge clk);

    // Both requests held: alternating service 0,1,0
    do_reset();
    op0 = 6'b010000; a0 = 32'd1; b0 = 32'd1;
    op1 = 6'b010000; a1 = 32'd2; b1 = 32'd2;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(gnt0 || gnt1) && n < 6);
      check($sformatf("rr%0d gnt", k), {gnt1, gnt0}, (k % 2 == 1) ? 2'b10 : 2'b01);
      @(negedge clk);
      check($sformatf("rr%0d done", k), {done1, done0}, (k % 2 == 1) ? 2'b10 : 2'b01);
      check($sformatf("rr%0d y", k), y, (k % 2 == 1) ? 32'd4 : 32'd2);
      if (k == 2) begin
        req0 = 0;
        req1 = 0;
      end
    end
    @(negedge clk);

    // Reset in the middle of EXEC aborts the transaction
    pulse_icc_ld(4'b0101);
    op0 = 6'b010100; a0 = 32'd7; b0 = 32'd8;
    req0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt0 && n < 6);
    check("abort gnt0", gnt0, 1'b1);
    reset = 1'b1;
    #1;
    check("abort outputs", {gnt1, gnt0, done1, done0, nzcv}, 8'd0);
    check("abort y/alu", {y, alu_op, alu_a, alu_b, alu_ci}, 103'd0);
    req0 = 1'b0;
    n = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done0 || done1) n++;
    end
    check("abort no done", n, 0);
    @(negedge clk);
    reset = 1'b0;
    op1 = 6'b000000; a1 = 32'd3; b1 = 32'd4;
    run_txn("post-abort req1", 1'b0, 1'b1, 1'b1, 32'd7, 4'b0000, 1'b0);

    // Randomized transactions against a transaction-level model
    do_reset();
    m_lsp = 1'b1;
    m_icc = 4'd0;
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        icc_in = 4'($urandom);
        m_icc = icc_in;
        pulse_icc_ld(icc_in);
      end
      case ($urandom_range(0, 2))
        0: begin rr0 = 1; rr1 = 0; end
        1: begin rr0 = 0; rr1 = 1; end
        default: begin rr0 = 1; rr1 = 1; end
      endcase
      op0 = {$urandom_range(0, 1) == 0 ? 2'b00 : 2'b01, 4'($urandom_range(0, 3) * 4)};
      op1 = {$urandom_range(0, 1) == 0 ? 2'b00 : 2'b01, 4'($urandom_range(0, 3) * 4)};
      if ($urandom_range(0, 7) == 0) op0 = 6'($urandom);
      a0 = $urandom; b0 = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? b1 : $urandom;
      b1 = $urandom;
      p = (rr0 && rr1) ? ~m_lsp : rr1;
      rop = p ? op1 : op0;
      r = p ? alu_fn(op1, a1, b1, m_icc[1]) : alu_fn(op0, a0, b0, m_icc[1]);
      run_txn($sformatf("rand%0d", t), rr0, rr1, p, r[35:4],
              (rop[5:4] == 2'b01) ? r[3:0] : m_icc, m_icc[1]);
      if (rop[5:4] == 2'b01) m_icc = r[3:0];
      m_lsp = p;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
